mcb_port_sched: RTL and testbench

Scheduler sharing one MCB user command port between a write-burst requester and a read-burst requester (the memory test write and read engines). Arbitrates round-robin, orders each burst's data phase and command issue the way the MCB requires (write data before WRITE command, READ command before read data), enforces burst-length limits and a data-phase watchdog, and keeps command counters and sticky error flags for debug.

---
 rtl/mcb_sched_pkg.sv | 22 ++
 rtl/mcb_rr_arb2.sv | 36 +++
 rtl/mcb_port_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_mcb_port_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_sched_pkg.sv
// Shared types and constants for the MCB command-port scheduler.
package mcb_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_DATA = 3'd1,
      ST_WR_CMD  = 3'd2,
      ST_RD_CMD  = 3'd3,
      ST_RD_DATA = 3'd4
   } sched_state_t;

   localparam logic [2:0] MCB_INSTR_WR = 3'b000;
   localparam logic [2:0] MCB_INSTR_RD = 3'b001;

   localparam int MCB_BL_MAX = 64;

   // A burst is legal when it moves at least one word and no more than bl_max.
   function automatic logic len_legal(input logic [6:0] len, input int bl_max);
      return (len != 7'd0) && ({25'd0, len} <= 32'(bl_max));
   endfunction

endpackage

// File: rtl/mcb_rr_arb2.sv
// Two-way round-robin picker. The last-served side only changes when the
// scheduler accepts the pick, so a refused request does not rotate priority.
module mcb_rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req_wr,
   input  logic req_rd,
   input  logic accept,
   output logic pick_wr,
   output logic pick_rd
);

   logic last_rd_reg;

   // On a tie the side that was not served last wins; a lone request always wins.
   always_comb begin
      pick_wr = 1'b0;
      pick_rd = 1'b0;
      if (req_wr && req_rd) begin
         pick_wr = last_rd_reg;
         pick_rd = !last_rd_reg;
      end else begin
         pick_wr = req_wr;
         pick_rd = req_rd;
      end
   end

   // Last-served starts as "read" so the first tie goes to the write side.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_rd_reg <= 1'b1;
      else if (accept)
         last_rd_reg <= pick_rd;
   end

endmodule

// File: rtl/mcb_port_sched.sv
// Shares one MCB command port between a write-burst and a read-burst engine.
// Writes push data before the WRITE command; reads issue READ before data.
// All outputs are registered; a watchdog bounds each data phase.
module mcb_port_sched
   import mcb_sched_pkg::*;
#(
   parameter int ADDR_W  = 30,
   parameter int BL_MAX  = MCB_BL_MAX,
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [6:0]        wr_len,
   input  logic [6:0]        rd_len,
   output logic              wr_gnt,
   output logic              rd_gnt,
   input  logic              wr_data_done,
   input  logic              rd_data_done,
   output logic              wr_reject,
   output logic              rd_reject,
   input  logic              cmd_full,
   output logic              cmd_en,
   output logic [2:0]        cmd_instr,
   output logic [ADDR_W-1:0] cmd_byte_addr,
   output logic [5:0]        cmd_bl,
   output logic [CNT_W-1:0]  wr_cmd_cnt,
   output logic [CNT_W-1:0]  rd_cmd_cnt,
   output logic              timeout_err,
   input  logic              err_clr
);

   localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);

   sched_state_t      state_reg, state_next;
   logic              wr_gnt_reg, wr_gnt_next;
   logic              rd_gnt_reg, rd_gnt_next;
   logic              wr_reject_reg, wr_reject_next;
   logic              rd_reject_reg, rd_reject_next;
   logic              cmd_en_reg, cmd_en_next;
   logic [2:0]        cmd_instr_reg, cmd_instr_next;
   logic [ADDR_W-1:0] cmd_addr_reg, cmd_addr_next;
   logic [5:0]        cmd_bl_reg, cmd_bl_next;
   logic [ADDR_W-1:0] lat_addr_reg, lat_addr_next;
   logic [6:0]        lat_len_reg, lat_len_next;
   logic [TIMER_W-1:0] timer_reg, timer_next;
   logic [CNT_W-1:0]  wr_cnt_reg, rd_cnt_reg;
   logic              timeout_err_reg;
   logic              issue_wr, issue_rd, timeout_set, accept;
   logic              pick_wr, pick_rd;

   mcb_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_wr  (wr_req),
      .req_rd  (rd_req),
      .accept  (accept),
      .pick_wr (pick_wr),
      .pick_rd (pick_rd)
   );

   // Next-state and next-output logic; command fields are loaded with each strobe.
   always_comb begin
      state_next     = state_reg;
      wr_gnt_next    = wr_gnt_reg;
      rd_gnt_next    = rd_gnt_reg;
      wr_reject_next = 1'b0;
      rd_reject_next = 1'b0;
      cmd_en_next    = 1'b0;
      cmd_instr_next = cmd_instr_reg;
      cmd_addr_next  = cmd_addr_reg;
      cmd_bl_next    = cmd_bl_reg;
      lat_addr_next  = lat_addr_reg;
      lat_len_next   = lat_len_reg;
      timer_next     = timer_reg;
      issue_wr       = 1'b0;
      issue_rd       = 1'b0;
      timeout_set    = 1'b0;
      accept         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (pick_wr) begin
               lat_addr_next = wr_addr;
               lat_len_next  = wr_len;
               if (len_legal(wr_len, BL_MAX)) begin
                  wr_gnt_next = 1'b1;
                  accept      = 1'b1;
                  timer_next  = '0;
                  state_next  = ST_WR_DATA;
               end else begin
                  wr_reject_next = 1'b1;
               end
            end else if (pick_rd) begin
               lat_addr_next = rd_addr;
               lat_len_next  = rd_len;
               if (len_legal(rd_len, BL_MAX)) begin
                  rd_gnt_next = 1'b1;
                  accept      = 1'b1;
                  state_next  = ST_RD_CMD;
               end else begin
                  rd_reject_next = 1'b1;
               end
            end
         end
         ST_WR_DATA: begin
            // Done beats the watchdog; a free FIFO lets the command go out next cycle.
            if (wr_data_done) begin
               state_next = ST_WR_CMD;
               issue_wr   = !cmd_full;
            end else if (timer_reg == TMO_LAST) begin
               timeout_set = 1'b1;
               wr_gnt_next = 1'b0;
               state_next  = ST_IDLE;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         ST_WR_CMD: begin
            if (cmd_en_reg) begin
               wr_gnt_next = 1'b0;
               state_next  = ST_IDLE;
            end else begin
               issue_wr = !cmd_full;
            end
         end
         ST_RD_CMD: begin
            if (cmd_en_reg) begin
               timer_next = '0;
               state_next = ST_RD_DATA;
            end else begin
               issue_rd = !cmd_full;
            end
         end
         ST_RD_DATA: begin
            if (rd_data_done) begin
               rd_gnt_next = 1'b0;
               state_next  = ST_IDLE;
            end else if (timer_reg == TMO_LAST) begin
               timeout_set = 1'b1;
               rd_gnt_next = 1'b0;
               state_next  = ST_IDLE;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (issue_wr || issue_rd) begin
         cmd_en_next    = 1'b1;
         cmd_instr_next = issue_rd ? MCB_INSTR_RD : MCB_INSTR_WR;
         cmd_addr_next  = lat_addr_reg;
         cmd_bl_next    = 6'(lat_len_reg - 7'd1);
      end
   end

   // State, grant/strobe and command-field registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         wr_gnt_reg    <= 1'b0;
         rd_gnt_reg    <= 1'b0;
         wr_reject_reg <= 1'b0;
         rd_reject_reg <= 1'b0;
         cmd_en_reg    <= 1'b0;
         cmd_instr_reg <= 3'b000;
         cmd_addr_reg  <= '0;
         cmd_bl_reg    <= 6'd0;
         lat_addr_reg  <= '0;
         lat_len_reg   <= 7'd0;
         timer_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         wr_gnt_reg    <= wr_gnt_next;
         rd_gnt_reg    <= rd_gnt_next;
         wr_reject_reg <= wr_reject_next;
         rd_reject_reg <= rd_reject_next;
         cmd_en_reg    <= cmd_en_next;
         cmd_instr_reg <= cmd_instr_next;
         cmd_addr_reg  <= cmd_addr_next;
         cmd_bl_reg    <= cmd_bl_next;
         lat_addr_reg  <= lat_addr_next;
         lat_len_reg   <= lat_len_next;
         timer_reg     <= timer_next;
      end
   end

   // Debug counters and sticky timeout flag; a clear overrides a same-cycle update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt_reg      <= '0;
         rd_cnt_reg      <= '0;
         timeout_err_reg <= 1'b0;
      end else if (err_clr) begin
         wr_cnt_reg      <= '0;
         rd_cnt_reg      <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         if (issue_wr && (wr_cnt_reg != '1))
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
         if (issue_rd && (rd_cnt_reg != '1))
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
         if (timeout_set)
            timeout_err_reg <= 1'b1;
      end
   end

   assign wr_gnt        = wr_gnt_reg;
   assign rd_gnt        = rd_gnt_reg;
   assign wr_reject     = wr_reject_reg;
   assign rd_reject     = rd_reject_reg;
   assign cmd_en        = cmd_en_reg;
   assign cmd_instr     = cmd_instr_reg;
   assign cmd_byte_addr = cmd_addr_reg;
   assign cmd_bl        = cmd_bl_reg;
   assign wr_cmd_cnt    = wr_cnt_reg;
   assign rd_cmd_cnt    = rd_cnt_reg;
   assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_mcb_port_sched.sv
// Directed bench for the MCB command-port scheduler (watchdog shortened to 16).
module tb_mcb_port_sched;

   localparam int ADDR_W = 30;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_req, rd_req;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [6:0]        wr_len, rd_len;
   logic              wr_gnt, rd_gnt;
   logic              wr_data_done, rd_data_done;
   logic              wr_reject, rd_reject;
   logic              cmd_full;
   logic              cmd_en;
   logic [2:0]        cmd_instr;
   logic [ADDR_W-1:0] cmd_byte_addr;
   logic [5:0]        cmd_bl;
   logic [CNT_W-1:0]  wr_cmd_cnt, rd_cmd_cnt;
   logic              timeout_err;
   logic              err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   mcb_port_sched #(
      .ADDR_W  (ADDR_W),
      .BL_MAX  (64),
      .TIMEOUT (16),
      .CNT_W   (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_req        (wr_req),
      .rd_req        (rd_req),
      .wr_addr       (wr_addr),
      .rd_addr       (rd_addr),
      .wr_len        (wr_len),
      .rd_len        (rd_len),
      .wr_gnt        (wr_gnt),
      .rd_gnt        (rd_gnt),
      .wr_data_done  (wr_data_done),
      .rd_data_done  (rd_data_done),
      .wr_reject     (wr_reject),
      .rd_reject     (rd_reject),
      .cmd_full      (cmd_full),
      .cmd_en        (cmd_en),
      .cmd_instr     (cmd_instr),
      .cmd_byte_addr (cmd_byte_addr),
      .cmd_bl        (cmd_bl),
      .wr_cmd_cnt    (wr_cmd_cnt),
      .rd_cmd_cnt    (rd_cmd_cnt),
      .timeout_err   (timeout_err),
      .err_clr       (err_clr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      rst = 1'b1;
      wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_len = 7'd0; rd_len = 7'd0;
      wr_data_done = 1'b0; rd_data_done = 1'b0;
      cmd_full = 1'b0; err_clr = 1'b0;

      // Reset state
      step(); step();
      chk("rst_wr_gnt", 64'(wr_gnt), 64'd0);
      chk("rst_rd_gnt", 64'(rd_gnt), 64'd0);
      chk("rst_rejects", 64'({wr_reject, rd_reject}), 64'd0);
      chk("rst_cmd_en", 64'(cmd_en), 64'd0);
      chk("rst_cmd_fields", 64'({cmd_instr, cmd_byte_addr, cmd_bl}), 64'd0);
      chk("rst_counters", 64'({wr_cmd_cnt, rd_cmd_cnt}), 64'd0);
      chk("rst_timeout_err", 64'(timeout_err), 64'd0);
      $display("reset: outputs checked");
      rst = 1'b0;

      // Single write, addr 0x400, len 64
      wr_req = 1'b1; wr_addr = 30'h400; wr_len = 7'd64;
      step();
      chk("w1_gnt", 64'(wr_gnt), 64'd1);
      step();
      chk("w1_no_cmd_before_done", 64'(cmd_en), 64'd0);
      wr_data_done = 1'b1;
      step();
      wr_data_done = 1'b0;
      chk("w1_cmd_en", 64'(cmd_en), 64'd1);
      chk("w1_instr", 64'(cmd_instr), 64'd0);
      chk("w1_addr", 64'(cmd_byte_addr), 64'h400);
      chk("w1_bl", 64'(cmd_bl), 64'd63);
      step();
      chk("w1_gnt_drop", 64'(wr_gnt), 64'd0);
      chk("w1_cmd_en_pulse", 64'(cmd_en), 64'd0);
      chk("w1_wr_cnt", 64'(wr_cmd_cnt), 64'd1);
      wr_req = 1'b0;
      $display("txn: write addr=0x400 len=64 done");

      // Illegal lengths: read len 0, then write len 65
      rd_req = 1'b1; rd_addr = 30'h10; rd_len = 7'd0;
      step();
      chk("rej_rd_pulse", 64'(rd_reject), 64'd1);
      chk("rej_rd_no_gnt", 64'({wr_gnt, rd_gnt}), 64'd0);
      rd_req = 1'b0;
      step();
      chk("rej_rd_once", 64'(rd_reject), 64'd0);
      chk("rej_rd_no_cmd", 64'(cmd_en), 64'd0);
      wr_req = 1'b1; wr_addr = 30'h20; wr_len = 7'd65;
      step();
      chk("rej_wr_pulse", 64'(wr_reject), 64'd1);
      chk("rej_wr_no_gnt", 64'({wr_gnt, rd_gnt}), 64'd0);
      wr_req = 1'b0;
      step();
      chk("rej_wr_once", 64'(wr_reject), 64'd0);
      chk("rej_wr_no_cmd", 64'(cmd_en), 64'd0);
      $display("txn: rejects rd_len=0 wr_len=65 done");

      // Write with cmd_full held for 20 cycles in WR_CMD
      wr_req = 1'b1; wr_addr = 30'h1230; wr_len = 7'd8;
      step();
      chk("full_gnt", 64'(wr_gnt), 64'd1);
      cmd_full = 1'b1;
      wr_data_done = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         wr_data_done = 1'b0;
         chk("full_stall", 64'(cmd_en), 64'd0);
      end
      cmd_full = 1'b0;
      step();
      chk("full_cmd_en", 64'(cmd_en), 64'd1);
      chk("full_addr", 64'(cmd_byte_addr), 64'h1230);
      chk("full_bl", 64'(cmd_bl), 64'd7);
      chk("full_no_timeout", 64'(timeout_err), 64'd0);
      step();
      chk("full_gnt_drop", 64'(wr_gnt), 64'd0);
      wr_req = 1'b0;
      $display("txn: write with cmd_full stall done");

      // Read with no data: watchdog fires after 16 cycles in RD_DATA
      rd_req = 1'b1; rd_addr = 30'h80; rd_len = 7'd16;
      step();
      chk("tmo_gnt", 64'(rd_gnt), 64'd1);
      step();
      chk("tmo_cmd_en", 64'(cmd_en), 64'd1);
      chk("tmo_instr", 64'(cmd_instr), 64'd1);
      for (int k = 0; k < 16; k++) begin
         step();
         chk("tmo_not_yet", 64'({timeout_err, rd_gnt}), 64'b01);
      end
      step();
      chk("tmo_err_set", 64'(timeout_err), 64'd1);
      chk("tmo_gnt_drop", 64'(rd_gnt), 64'd0);
      rd_req = 1'b0;
      step();
      chk("tmo_sticky", 64'(timeout_err), 64'd1);
      chk("cnt_wr_before_clr", 64'(wr_cmd_cnt), 64'd2);
      chk("cnt_rd_before_clr", 64'(rd_cmd_cnt), 64'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("clr_timeout_err", 64'(timeout_err), 64'd0);
      chk("clr_counters", 64'({wr_cmd_cnt, rd_cmd_cnt}), 64'd0);
      $display("txn: read timeout and err_clr done");

      // Both requesters continuously: W, R, W, R
      wr_req = 1'b1; wr_addr = 30'h2000; wr_len = 7'd4;
      rd_req = 1'b1; rd_addr = 30'h3000; rd_len = 7'd2;
      for (int i = 0; i < 4; i++) begin
         step();
         if ((i % 2) == 0) begin
            chk("rr_wr_gnt", 64'({wr_gnt, rd_gnt}), 64'b10);
            wr_data_done = 1'b1;
            step();
            wr_data_done = 1'b0;
            chk("rr_wr_cmd", 64'({cmd_en, cmd_instr, cmd_bl}), 64'({1'b1, 3'b000, 6'd3}));
            step();
            chk("rr_wr_end", 64'(wr_gnt), 64'd0);
         end else begin
            chk("rr_rd_gnt", 64'({wr_gnt, rd_gnt}), 64'b01);
            step();
            chk("rr_rd_cmd", 64'({cmd_en, cmd_instr, cmd_bl}), 64'({1'b1, 3'b001, 6'd1}));
            chk("rr_rd_addr", 64'(cmd_byte_addr), 64'h3000);
            step();
            chk("rr_rd_data_phase", 64'({cmd_en, rd_gnt}), 64'b01);
            rd_data_done = 1'b1;
            step();
            rd_data_done = 1'b0;
            chk("rr_rd_end", 64'(rd_gnt), 64'd0);
         end
         $display("txn: round-robin slot %0d done", i);
      end
      wr_req = 1'b0; rd_req = 1'b0;
      chk("rr_cnts", 64'({wr_cmd_cnt, rd_cmd_cnt}), 64'({16'd2, 16'd2}));

      // Reset in the middle of a read data phase
      step();
      rd_req = 1'b1; rd_addr = 30'h40; rd_len = 7'd1;
      step();
      chk("mid_gnt", 64'(rd_gnt), 64'd1);
      step();
      chk("mid_cmd_en", 64'(cmd_en), 64'd1);
      step();
      chk("mid_in_data", 64'({rd_gnt, cmd_instr}), 64'({1'b1, 3'b001}));
      rst = 1'b1;
      #1;
      chk("mid_rst_gnts", 64'({wr_gnt, rd_gnt}), 64'd0);
      chk("mid_rst_cmd", 64'({cmd_en, cmd_instr, cmd_byte_addr, cmd_bl}), 64'd0);
      chk("mid_rst_cnts", 64'({wr_cmd_cnt, rd_cmd_cnt, timeout_err}), 64'd0);
      step();
      rst = 1'b0;
      wr_req = 1'b1; wr_addr = 30'h500; wr_len = 7'd2;
      step();
      chk("post_rst_tie_wr_first", 64'({wr_gnt, rd_gnt}), 64'b10);
      chk("post_rst_no_cmd", 64'(cmd_en), 64'd0);
      wr_req = 1'b0; rd_req = 1'b0;
      $display("txn: reset mid-read then tie -> write done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
